// File: rtl/bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter:
// FSM state encoding and digit arithmetic constants.
package bcd_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_CONV = 1'b1
    } state_t;

    localparam int         BCD_DIGIT_W = 4;
    localparam logic [3:0] ADD3_THRESH = 4'd5;

endpackage

// File: rtl/bcd_add3.sv
// Single-digit double-dabble corrector: adds 3 to a digit of 5 or more so the
// following left shift carries correctly into the next decimal digit.
module bcd_add3
    import bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] i_digit,
    output logic [BCD_DIGIT_W-1:0] o_digit
);

    // Input is at most 9 in a valid scratch digit, so the result stays <= 12.
    assign o_digit = (i_digit >= ADD3_THRESH) ? (i_digit + 4'd3) : i_digit;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter, one operand bit per clock (shift-add-3).
// Results and overflow are registered and only change on the done pulse.
module bin_to_bcd_seq
    import bcd_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic [WIDTH-1:0]            bin,
    output logic                        busy,
    output logic                        done,
    output logic [BCD_DIGIT_W*DIGITS-1:0] bcd,
    output logic                        overflow
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam int SCR_W = BCD_DIGIT_W * DIGITS;

    state_t                 r_state;
    logic [CNT_W-1:0]       r_cnt;
    logic [WIDTH-1:0]       r_shift;
    logic [SCR_W-1:0]       r_scratch;
    logic                   r_ovf_scr;
    logic                   r_busy;
    logic                   r_done;
    logic [SCR_W-1:0]       r_bcd;
    logic                   r_ovf;

    logic [SCR_W-1:0]       w_adj;
    logic [SCR_W-1:0]       w_next_scratch;
    logic [WIDTH-1:0]       w_next_shift;
    logic                   w_out_bit;
    logic                   w_last;

    genvar g;
    generate
        for (g = 0; g < DIGITS; g++) begin : g_digit
            bcd_add3 u_add3 (
                .i_digit (r_scratch[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
                .o_digit (w_adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
            );
        end
    endgenerate

    // {scratch, shift} shifts left as one register; the corrected top bit
    // falls off the end and records that the value no longer fits.
    assign w_next_scratch = {w_adj[SCR_W-2:0], r_shift[WIDTH-1]};
    assign w_next_shift   = r_shift << 1;
    assign w_out_bit      = w_adj[SCR_W-1];
    assign w_last         = (r_cnt == CNT_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_shift   <= '0;
            r_scratch <= '0;
            r_ovf_scr <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_bcd     <= '0;
            r_ovf     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_shift   <= bin;
                        r_scratch <= '0;
                        r_ovf_scr <= 1'b0;
                        r_cnt     <= CNT_W'(WIDTH);
                        r_busy    <= 1'b1;
                        r_state   <= ST_CONV;
                    end
                end
                ST_CONV: begin
                    r_shift   <= w_next_shift;
                    r_scratch <= w_next_scratch;
                    r_ovf_scr <= r_ovf_scr | w_out_bit;
                    r_cnt     <= r_cnt - CNT_W'(1);
                    if (w_last) begin
                        r_bcd   <= w_next_scratch;
                        r_ovf   <= r_ovf_scr | w_out_bit;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign bcd      = r_bcd;
    assign overflow = r_ovf;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Bench for bin_to_bcd_seq: three configurations (8/3, 16/5, 8/2) driven by
// scenario tasks; expected results come from a divide-by-ten reference model.
module tb_bin_to_bcd_seq;

    logic        clk;
    logic        rst_n;

    logic        a_start, a_busy, a_done, a_ovf;
    logic [7:0]  a_bin;
    logic [11:0] a_bcd;

    logic        b_start, b_busy, b_done, b_ovf;
    logic [15:0] b_bin;
    logic [19:0] b_bcd;

    logic        c_start, c_busy, c_done, c_ovf;
    logic [7:0]  c_bin;
    logic [7:0]  c_bcd;

    int n_cmp;
    int n_fail;
    logic [20:0] exp_q[$];

    bin_to_bcd_seq #(.WIDTH(8), .DIGITS(3)) u_a (
        .clk(clk), .rst_n(rst_n), .start(a_start), .bin(a_bin),
        .busy(a_busy), .done(a_done), .bcd(a_bcd), .overflow(a_ovf)
    );

    bin_to_bcd_seq #(.WIDTH(16), .DIGITS(5)) u_b (
        .clk(clk), .rst_n(rst_n), .start(b_start), .bin(b_bin),
        .busy(b_busy), .done(b_done), .bcd(b_bcd), .overflow(b_ovf)
    );

    bin_to_bcd_seq #(.WIDTH(8), .DIGITS(2)) u_c (
        .clk(clk), .rst_n(rst_n), .start(c_start), .bin(c_bin),
        .busy(c_busy), .done(c_done), .bcd(c_bcd), .overflow(c_ovf)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int width_of(input int inst);
        return (inst == 1) ? 16 : 8;
    endfunction

    function automatic int digits_of(input int inst);
        case (inst)
            0:       return 3;
            1:       return 5;
            default: return 2;
        endcase
    endfunction

    // {overflow, bcd} zero-extended to 20 bits
    function automatic logic [20:0] model(input int val, input int digits);
        logic [20:0] r;
        int p;
        int lim;
        r   = '0;
        p   = val;
        lim = 1;
        for (int d = 0; d < digits; d++) begin
            r[d*4 +: 4] = 4'(p % 10);
            p   = p / 10;
            lim = lim * 10;
        end
        r[20] = (val >= lim);
        return r;
    endfunction

    function automatic logic sel_done(input int inst);
        case (inst)
            0:       return a_done;
            1:       return b_done;
            default: return c_done;
        endcase
    endfunction

    function automatic logic sel_busy(input int inst);
        case (inst)
            0:       return a_busy;
            1:       return b_busy;
            default: return c_busy;
        endcase
    endfunction

    function automatic logic [20:0] sel_result(input int inst);
        case (inst)
            0:       return {a_ovf, 8'h0, a_bcd};
            1:       return {b_ovf, b_bcd};
            default: return {c_ovf, 12'h0, c_bcd};
        endcase
    endfunction

    // driver
    task automatic drive_start(input int inst, input int val, input logic s);
        case (inst)
            0:       begin a_start = s; a_bin = 8'(val);  end
            1:       begin b_start = s; b_bin = 16'(val); end
            default: begin c_start = s; c_bin = 8'(val);  end
        endcase
    endtask

    // Called #1 after a rising edge with the instance idle; returns #1 after
    // the edge that produced done (i.e. inside the done cycle).
    task automatic do_conv(input int inst, input int val);
        logic [20:0] exp_v;
        logic [20:0] got;
        int lat;
        logic seen;
        drive_start(inst, val, 1'b1);
        exp_q.push_back(model(val, digits_of(inst)));
        @(posedge clk); #1;
        drive_start(inst, val, 1'b0);
        n_cmp++;
        if (sel_busy(inst) !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_after_accept inst=%0d bin=%0d got=%b want=1", inst, val, sel_busy(inst));
        end
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (sel_done(inst) === 1'b1) seen = 1'b1;
        end
        exp_v = exp_q.pop_front();
        n_cmp++;
        if (!seen) begin
            n_fail++;
            $display("FAIL done_timeout inst=%0d bin=%0d got=no done want=done", inst, val);
            return;
        end
        if (lat != width_of(inst) || sel_busy(inst) !== 1'b0) begin
            n_fail++;
            $display("FAIL latency inst=%0d bin=%0d got=%0d busy=%b want=%0d busy=0",
                     inst, val, lat, sel_busy(inst), width_of(inst));
        end
        got = sel_result(inst);
        n_cmp++;
        if (got !== exp_v) begin
            n_fail++;
            $display("FAIL result inst=%0d bin=%0d got=ovf%b/%h want=ovf%b/%h",
                     inst, val, got[20], got[19:0], exp_v[20], exp_v[19:0]);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive_start(0, 0, 1'b0);
        drive_start(1, 0, 1'b0);
        drive_start(2, 0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({a_busy, a_done, a_ovf, a_bcd, b_busy, b_done, b_ovf, b_bcd,
             c_busy, c_done, c_ovf, c_bcd} !== '0) begin
            n_fail++;
            $display("FAIL reset_values got=a%b%b%b/%h b%b%b%b/%h c%b%b%b/%h want=all zero",
                     a_busy, a_done, a_ovf, a_bcd, b_busy, b_done, b_ovf, b_bcd,
                     c_busy, c_done, c_ovf, c_bcd);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_sweep_8_3();
        for (int v = 0; v < 256; v++) do_conv(0, v);
    endtask

    task automatic test_wide_16_5();
        do_conv(1, 65535);
        do_conv(1, 0);
        do_conv(1, 40960);
        do_conv(1, int'($urandom_range(1, 65534)));
    endtask

    task automatic test_overflow_8_2();
        do_conv(2, 100);
        do_conv(2, 99);
        do_conv(2, 255);
        do_conv(2, int'($urandom_range(0, 99)));
    endtask

    task automatic test_ignored_start();
        int dones;
        int first_lat;
        logic [20:0] got;
        logic [20:0] exp_v;
        drive_start(0, 200, 1'b1);
        exp_q.push_back(model(200, 3));
        @(posedge clk); #1;
        drive_start(0, 200, 1'b0);
        dones = 0;
        first_lat = 0;
        got = '0;
        for (int i = 1; i <= 20; i++) begin
            if (i == 3) drive_start(0, 17, 1'b1);
            @(posedge clk); #1;
            if (i == 3) drive_start(0, 17, 1'b0);
            if (a_done === 1'b1) begin
                dones++;
                if (dones == 1) begin
                    first_lat = i;
                    got = sel_result(0);
                end
            end
        end
        exp_v = exp_q.pop_front();
        n_cmp++;
        if (dones != 1 || first_lat != 8) begin
            n_fail++;
            $display("FAIL ignored_start_dones got=%0d dones first at %0d want=1 done at 8", dones, first_lat);
        end
        n_cmp++;
        if (got !== exp_v) begin
            n_fail++;
            $display("FAIL ignored_start_result got=%h want=%h", got, exp_v);
        end
    endtask

    task automatic test_back_to_back();
        // second start is driven inside the done cycle of the first
        do_conv(0, 7);
        do_conv(0, 42);
        do_conv(1, 12345);
        do_conv(1, 9999);
    endtask

    task automatic test_reset_abort();
        int dones;
        drive_start(0, 255, 1'b1);
        @(posedge clk); #1;
        drive_start(0, 255, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({a_busy, a_done, a_ovf, a_bcd} !== '0) begin
            n_fail++;
            $display("FAIL abort_outputs got=busy%b done%b ovf%b bcd%h want=all zero",
                     a_busy, a_done, a_ovf, a_bcd);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            if (a_done === 1'b1) dones++;
        end
        n_cmp++;
        if (dones != 0) begin
            n_fail++;
            $display("FAIL abort_no_done got=%0d dones want=0", dones);
        end
        do_conv(0, 128);
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        test_reset();
        test_sweep_8_3();
        test_wide_16_5();
        test_overflow_8_2();
        test_ignored_start();
        test_back_to_back();
        test_reset_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
